denge_izleyici: RTL and testbench
=================================

DENGE_IZLEYICI -- requirements
Module: denge_izleyici

Interface
REQ-001 The block SHALL have parameter N_CUBUK, default 3, giving the number of beams; it SHALL be odd and at least 1.
REQ-002 The block SHALL have parameter W, default 2, giving the weight width per side per beam, in bits.
REQ-003 The block SHALL have parameter DEBOUNCE, default 4, giving the consecutive valid samples required before the stable output changes; it SHALL be at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port valid_in, input, 1 bit: A and B are sampled this cycle.
REQ-007 The block SHALL have port A, input, N_CUBUK*W bits: left-pan weights; beam i is A[i*W +: W], with beam 0 as the left beam.
REQ-008 The block SHALL have port B, input, N_CUBUK*W bits: right-pan weights, with the same slicing as A.
REQ-009 The block SHALL have port D, output, 2 bits: debounced system state.
REQ-010 The block SHALL have port D_ham, output, 2 bits: undebounced system decision.
REQ-011 The block SHALL have port valid_out, output, 1 bit: D_ham is valid this cycle.
REQ-012 The block SHALL have port degisti, output, 1 bit: one-cycle pulse when D changes.

Function
REQ-013 State codes SHALL be SEVIYE = 00 (level), SOL = 01 (falls left) and SAG = 10 (falls right); code 11 SHALL never be driven.
REQ-014 Per-beam stage 1 SHALL give SOL if A_i > B_i, SAG if B_i > A_i, and SEVIYE if they are equal, using an unsigned W-bit compare.
REQ-015 Stage 1 codes SHALL be registered on a valid_in cycle; valid SHALL propagate with them.
REQ-016 Stage 2 SHALL count n_sol and n_sag, each of width clog2(N_CUBUK+1); level beams SHALL be excluded from both counts.
REQ-017 Stage 2 decision SHALL be SAG if n_sag > n_sol, SOL if n_sol > n_sag, and SEVIYE if they are equal (including all beams level).
REQ-018 D_ham and valid_out SHALL be registered, giving a latency of exactly 2 cycles from the valid_in sample; valid_in gaps SHALL produce valid_out gaps in the same positions.
REQ-019 The debounce FSM SHALL have states SEVIYE, SOL and SAG, and D SHALL equal the current state.
REQ-020 The debounce candidate register and saturating counter SHALL advance only on valid_out cycles; on non-valid cycles both SHALL hold.
REQ-021 On a valid_out with D_ham equal to D, the counter SHALL clear to 0.
REQ-022 On a valid_out with D_ham not equal to D and equal to the candidate, the counter SHALL increment; otherwise candidate SHALL be set to D_ham and the counter to 1.
REQ-023 When the counter reaches DEBOUNCE, in the same clock edge the state SHALL become the candidate, the counter SHALL clear and degisti SHALL be 1 for one cycle.
REQ-024 With DEBOUNCE = 1, D SHALL follow D_ham one cycle later on every change.
REQ-025 A direct SOL-to-SAG transition SHALL be legal; no intermediate SEVIYE state is required.

Reset
REQ-026 On rst assertion, asynchronously: D, D_ham, the stage 1 codes, the candidate and the state SHALL be SEVIYE; valid_out, degisti and the counter SHALL be 0.
REQ-027 rst asserted mid-debounce SHALL discard all partial progress; after release, the first valid_out SHALL appear 2 cycles after the first valid_in.

Structure
REQ-028 A shared package denge_pkg SHALL hold the state-code constants SEVIYE, SOL and SAG and the 2-bit state typedef.
REQ-029 Per-beam compare SHALL be sub-module agirlikli_cubuk (W-bit A, W-bit B, 2-bit code), instantiated N_CUBUK times via generate.
REQ-030 The counting, decision and FSM logic SHALL live in denge_izleyici.

Verification
REQ-031 Scenario: defaults, A = {2,1,3}, B = {1,2,0} valid for 1 cycle -> codes SOL, SAG, SOL; D_ham = SOL with valid_out on cycle +2; D unchanged.
REQ-032 Scenario: all beams equal (A = B = 6'h15) -> D_ham = SEVIYE; n_sol = n_sag = 0.
REQ-033 Scenario: N_CUBUK = 3, W = 2, one beam SOL, one SAG, one level -> D_ham = SEVIYE (tie).
REQ-034 Scenario: SAG decision held 4 consecutive valid samples -> D = SAG after the 4th, with a single degisti pulse; 3 samples followed by 1 SOL sample -> D stays SEVIYE and candidate = SOL with counter 1.
REQ-035 Scenario: SAG samples with a valid_in gap of 5 idle cycles between samples 2 and 3 -> the counter holds through the gap and D switches after sample 4.
REQ-036 Scenario: rst pulsed after 3 of 4 SAG samples -> D = SEVIYE and counter 0 immediately; 4 fresh samples are needed to switch.

Source files
------------

// File: rtl/denge_pkg.sv
// Shared state codes for the beam-balance monitor, plus the majority helper
// that turns left/right beam counts into a system decision.
package denge_pkg;

  typedef enum logic [1:0] {
    SEVIYE = 2'b00,
    SOL    = 2'b01,
    SAG    = 2'b10
  } durum_t;

  // Majority vote between left-falling and right-falling beams; a tie is level.
  function automatic durum_t karar(input int unsigned n_sol, input int unsigned n_sag);
    if (n_sag > n_sol)      return SAG;
    else if (n_sol > n_sag) return SOL;
    else                    return SEVIYE;
  endfunction

endpackage

// File: rtl/agirlikli_cubuk.sv
// One beam: unsigned compare of left and right pan weights into a tilt code.
module agirlikli_cubuk
  import denge_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output durum_t       kod
);

  always_comb begin
    if (a > b)      kod = SOL;
    else if (b > a) kod = SAG;
    else            kod = SEVIYE;
  end

endmodule

// File: rtl/denge_izleyici.sv
// Beam-balance monitor: per-beam compare, majority decision (2-cycle latency)
// and a debounce FSM that only moves D after DEBOUNCE agreeing samples.
module denge_izleyici
  import denge_pkg::*;
#(
  parameter int N_CUBUK  = 3,
  parameter int W        = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [N_CUBUK*W-1:0] A,
  input  logic [N_CUBUK*W-1:0] B,
  output logic [1:0]           D,
  output logic [1:0]           D_ham,
  output logic                 valid_out,
  output logic                 degisti
);

  localparam int CW = $clog2(N_CUBUK + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  durum_t          kod_c [N_CUBUK];
  durum_t          kod_q [N_CUBUK];
  logic            v1_q;
  logic [CW-1:0]   n_sol;
  logic [CW-1:0]   n_sag;
  durum_t          ham_q;
  durum_t          state;
  durum_t          cand;
  logic [DW-1:0]   cnt;
  durum_t          cand_nx;
  logic [DW-1:0]   cnt_nx;

  for (genvar g = 0; g < N_CUBUK; g++) begin : g_cubuk
    agirlikli_cubuk #(.W(W)) u_cubuk (
      .a  (A[g*W +: W]),
      .b  (B[g*W +: W]),
      .kod(kod_c[g])
    );
  end

  // Stage 1: beam codes captured only on valid samples; valid always advances.
  // NOTE: the code array is only N_CUBUK flops, so it gets a real reset rather
  // than being treated as uninitialised storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      for (int i = 0; i < N_CUBUK; i++) kod_q[i] <= SEVIYE;
    end else begin
      // NOTE: non-blocking everywhere in clocked blocks so every register sees
      // the pre-edge value of every other register.
      v1_q <= valid_in;
      if (valid_in) begin
        for (int i = 0; i < N_CUBUK; i++) kod_q[i] <= kod_c[i];
      end
    end
  end

  // NOTE: every always_comb output is assigned a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    n_sol = '0;
    n_sag = '0;
    for (int i = 0; i < N_CUBUK; i++) begin
      if (kod_q[i] == SOL) n_sol = n_sol + CW'(1);
      if (kod_q[i] == SAG) n_sag = n_sag + CW'(1);
    end
  end

  // Stage 2: registered raw decision; it holds its value across invalid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ham_q     <= SEVIYE;
      valid_out <= 1'b0;
    end else begin
      valid_out <= v1_q;
      if (v1_q) ham_q <= karar(32'(n_sol), 32'(n_sag));
    end
  end

  // Next candidate/count for a valid sample; the counter saturates at DEBOUNCE.
  always_comb begin
    cand_nx = cand;
    cnt_nx  = '0;
    if (ham_q != state) begin
      if (ham_q == cand) begin
        cnt_nx = (cnt == DW'(DEBOUNCE)) ? cnt : cnt + DW'(1);
      end else begin
        cand_nx = ham_q;
        cnt_nx  = DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEVIYE;
      cand    <= SEVIYE;
      cnt     <= '0;
      degisti <= 1'b0;
    end else begin
      degisti <= 1'b0;
      if (valid_out) begin
        cand <= cand_nx;
        if (cnt_nx == DW'(DEBOUNCE)) begin
          state   <= cand_nx;
          cnt     <= '0;
          degisti <= 1'b1;
        end else begin
          cnt <= cnt_nx;
        end
      end
    end
  end

  assign D     = state;
  assign D_ham = ham_q;

endmodule

// File: tb/tb_denge_izleyici.sv
// Self-checking bench for denge_izleyici: directed scenarios plus random
// traffic compared against a sample-history reference model.
module tb_denge_izleyici;

  localparam int N   = 3;
  localparam int W   = 2;
  localparam int DEB = 4;
  localparam int NB  = N * W;

  localparam logic [1:0] C_LVL   = 2'b00;
  localparam logic [1:0] C_LEFT  = 2'b01;
  localparam logic [1:0] C_RIGHT = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [NB-1:0] A;
  logic [NB-1:0] B;
  logic [1:0]    D;
  logic [1:0]    D_ham;
  logic          valid_out;
  logic          degisti;

  always #5 clk = ~clk;

  denge_izleyici #(.N_CUBUK(N), .W(W), .DEBOUNCE(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .A        (A),
    .B        (B),
    .D        (D),
    .D_ham    (D_ham),
    .valid_out(valid_out),
    .degisti  (degisti)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: output history indexed by clock edge since reset.
  bit         ev [0:4095];
  logic [1:0] eh [0:4095];
  int         e;
  logic [1:0] m_d;
  logic [1:0] m_cand;
  int         m_cnt;
  bit         m_deg;
  int         deg_seen;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_dec(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int left  = 0;
    int right = 0;
    for (int i = 0; i < N; i++) begin
      int ai;
      int bi;
      ai = int'((a >> (i * W)) & NB'((1 << W) - 1));
      bi = int'((b >> (i * W)) & NB'((1 << W) - 1));
      if (ai > bi) left++;
      if (bi > ai) right++;
    end
    if (right > left) return C_RIGHT;
    if (left > right) return C_LEFT;
    return C_LVL;
  endfunction

  task automatic model_reset();
    e        = 1;
    ev[0]    = 1'b0;
    ev[1]    = 1'b0;
    eh[0]    = C_LVL;
    eh[1]    = C_LVL;
    m_d      = C_LVL;
    m_cand   = C_LVL;
    m_cnt    = 0;
    m_deg    = 1'b0;
    deg_seen = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    #1;
    check("rst_d", int'(D), 0);
    check("rst_d_ham", int'(D_ham), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_degisti", int'(degisti), 0);
    check("rst_cnt", int'(dut.cnt), 0);
    check("rst_cand", int'(dut.cand), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic tick(input bit v, input logic [NB-1:0] a, input logic [NB-1:0] b);
    valid_in = v;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
    ev[e+1] = v;
    eh[e+1] = v ? ref_dec(a, b) : eh[e];
    m_deg   = 1'b0;
    if (ev[e-1]) begin
      if (eh[e-1] == m_d) begin
        m_cnt = 0;
      end else begin
        if (eh[e-1] == m_cand) begin
          m_cnt++;
        end else begin
          m_cand = eh[e-1];
          m_cnt  = 1;
        end
        if (m_cnt == DEB) begin
          m_d   = m_cand;
          m_cnt = 0;
          m_deg = 1'b1;
        end
      end
    end
    if (degisti) deg_seen++;
    check("valid_out", int'(valid_out), int'(ev[e]));
    check("d_ham", int'(D_ham), int'(eh[e]));
    check("d", int'(D), int'(m_d));
    check("degisti", int'(degisti), int'(m_deg));
    e++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, A, B);
  endtask

  localparam logic [NB-1:0] ALL0 = '0;
  localparam logic [NB-1:0] ALL1 = '1;

  initial begin
    logic [NB-1:0] ra;
    logic [NB-1:0] rb;
    A = '0;
    B = '0;
    do_reset();

    // Mixed beams: beam0 3>0, beam1 1<2, beam2 2>1 -> falls left.
    tick(1'b1, {2'd2, 2'd1, 2'd3}, {2'd1, 2'd2, 2'd0});
    tick(1'b0, A, B);
    check("mix_valid", int'(valid_out), 1);
    check("mix_ham", int'(D_ham), int'(C_LEFT));
    idle(4);
    check("mix_d_hold", int'(D), int'(C_LVL));

    // All beams level.
    tick(1'b1, 6'h15, 6'h15);
    check("lvl_n_sol", int'(dut.n_sol), 0);
    check("lvl_n_sag", int'(dut.n_sag), 0);
    tick(1'b0, A, B);
    check("lvl_ham", int'(D_ham), int'(C_LVL));

    // One left, one right, one level -> tie.
    tick(1'b1, {2'd1, 2'd2, 2'd0}, {2'd3, 2'd1, 2'd0});
    tick(1'b0, A, B);
    check("tie_ham", int'(D_ham), int'(C_LVL));
    idle(3);

    // Four right samples switch D with a single pulse.
    do_reset();
    repeat (4) tick(1'b1, ALL0, ALL1);
    idle(4);
    check("sag4_d", int'(D), int'(C_RIGHT));
    check("sag4_pulses", deg_seen, 1);

    // Three right then one left: candidate restarts.
    do_reset();
    repeat (3) tick(1'b1, ALL0, ALL1);
    tick(1'b1, ALL1, ALL0);
    idle(3);
    check("sag3sol_d", int'(D), int'(C_LVL));
    check("sag3sol_cand", int'(dut.cand), int'(C_LEFT));
    check("sag3sol_cnt", int'(dut.cnt), 1);

    // Gap of five idle cycles between samples 2 and 3.
    do_reset();
    repeat (2) tick(1'b1, ALL0, ALL1);
    idle(5);
    tick(1'b1, ALL0, ALL1);
    idle(3);
    check("gap_cnt3", int'(dut.cnt), 3);
    check("gap_d_before", int'(D), int'(C_LVL));
    tick(1'b1, ALL0, ALL1);
    idle(3);
    check("gap_d_after", int'(D), int'(C_RIGHT));

    // Reset after three of four samples discards progress.
    do_reset();
    repeat (3) tick(1'b1, ALL0, ALL1);
    idle(3);
    check("mid_cnt3", int'(dut.cnt), 3);
    do_reset();
    repeat (3) tick(1'b1, ALL0, ALL1);
    idle(3);
    check("mid_d_3", int'(D), int'(C_LVL));
    tick(1'b1, ALL0, ALL1);
    idle(3);
    check("mid_d_4", int'(D), int'(C_RIGHT));

    // Random traffic with sticky patterns so debounce runs complete.
    do_reset();
    ra = NB'($urandom);
    rb = NB'($urandom);
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ra = NB'($urandom);
        rb = NB'($urandom);
      end
      tick($urandom_range(0, 3) != 0, ra, rb);
      if (i % 300 == 299) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
